return_predict_checker: RTL
===========================

Name: return_predict_checker

Overview:
- Sits downstream of the return address stack, between decode/fetch prediction and execute-stage jalr resolution.
- Buffers each predicted return address in flight in a small FIFO.
- When the jalr resolves in execute, compares the real target against the oldest prediction. On mismatch, issues a registered redirect, flushes younger predictions, and holds the front end for a fixed recovery window.

Parameters:
- ADDR_W, 64, address width of predicted and resolved targets.
- DEPTH, 4, number of in-flight predictions; power of two, >= 2.
- RECOVER_CYCLES, 2, cycles spent in RECOVER after a redirect; >= 1.

Ports:
- clk_in  input  1  system clock, all logic on posedge.
- rst_in  input  1  synchronous, active-high reset.
- pred_valid_in  input  1  a return was predicted this cycle (driven by the RAS return signal).
- pred_addr_in  input  ADDR_W  predicted return address (the RAS return address output).
- resolve_valid_in  input  1  a return-type jalr resolved in execute this cycle.
- resolve_target_in  input  ADDR_W  computed jalr target, (rs1+imm).
- flush_in  input  1  external pipeline flush (trap/branch mispredict).
- redirect_out  output  1  one-cycle pulse: fetch must restart at redirect_addr_out.
- redirect_addr_out  output  ADDR_W  corrected target; held until the next redirect.
- recover_out  output  1  high while in RECOVER; front end must not predict.
- full_out  output  1  count == DEPTH.
- empty_out  output  1  count == 0.
- count_out  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values: all outputs 0 except empty_out=1. FIFO pointers and count are 0. State is RUN. Counters are 0. FIFO storage is not reset.
- Push: occurs when pred_valid_in & ~full_out & state==RUN & ~flush_in & ~mismatch. pred_addr_in is written at the tail and the tail advances (wraps modulo DEPTH). If pred_valid_in arrives while full_out is set, the prediction is dropped with no error. full_out depends on the registered count only; a pop in the same cycle does not free the slot.
- Compare target: resolve_target_in with bit 0 forced to 0 (jalr semantics) versus the head entry. Compare all ADDR_W bits.
- Resolve with a non-empty FIFO:
  - Head is popped.
  - Match: no action.
  - Mismatch: next cycle redirect_out=1, redirect_addr_out=masked target, FIFO cleared (head=tail=count=0), any same-cycle push discarded, state -> RECOVER.
- Resolve with an empty FIFO (return not predicted): treated as a mismatch, with identical redirect behaviour.
- Simultaneous push and matching pop: both occur; count unchanged.
- flush_in:
  - Clears the FIFO, forces state RUN, clears the recovery counter, and suppresses any redirect computed in the same cycle.
  - Has priority over push, resolve and recovery.
- Latency: resolve to redirect_out is exactly 1 cycle (registered).
- FSM:
  - RUN: pushes and resolves are accepted. A mismatch loads recov_cnt = RECOVER_CYCLES-1 and moves to RECOVER.
  - RECOVER: recover_out=1; pushes are ignored; resolve_valid_in is ignored (wrong-path). recov_cnt decrements each cycle; at 0 the state returns to RUN next cycle. Total RECOVER duration is RECOVER_CYCLES cycles, starting in the same cycle redirect_out pulses.
- Reset mid-RECOVER: state returns to RUN and outputs return to reset values on the next edge.

Optional Feature:
- Macro: RET_PREDICT_STATS_EN.
- Defined: adds outputs hit_count_out [31:0] and miss_count_out [31:0].
  - hit_count_out increments on each matched resolve in RUN.
  - miss_count_out increments on each mismatched or empty resolve in RUN.
  - Both saturate at 32'hFFFF_FFFF, are cleared by rst_in, and are not cleared by flush_in.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push 0x1000 and 0x2000; resolve 0x1000 then 0x2001 -> no redirect_out; count_out 2->1->0; empty_out=1.
- Push 0x1000; resolve 0x1400 -> cycle+1: redirect_out=1 for exactly 1 cycle, redirect_addr_out=0x1400, count_out=0; recover_out high 2 cycles; a push during RECOVER is ignored.
- Push DEPTH=4 entries 0x10,0x20,0x30,0x40; attempt fifth push 0x50 -> full_out=1 and 0x50 dropped. Resolve four times with matching targets -> no redirect; wrap-around is then exercised by 4 further push/resolve pairs.
- Resolve 0x3000 with empty FIFO -> redirect_out pulse, redirect_addr_out=0x3000.
- Mismatched resolve with flush_in high in the same cycle -> no redirect_out; FIFO empty; state RUN.
- With RET_PREDICT_STATS_EN: 3 matched and 2 mismatched resolves separated by recovery -> hit_count_out=3, miss_count_out=2; rst_in -> both 0.

Source files
------------

// File: rtl/return_predict_checker.sv
// rtl/return_predict_checker.sv - return-address prediction checker with redirect and recovery window
//
// Holds predicted return addresses in a small FIFO and checks each one against
// the jalr target that execute resolves. When a prediction is wrong, it redirects
// fetch, drops all younger predictions, and holds off new predictions for a fixed
// recovery window.
//
// Optional feature macro: RET_PREDICT_STATS_EN (adds hit/miss counters)
//
// Ports:
//   clk_in            - system clock, posedge
//   rst_in            - synchronous active-high reset
//   pred_valid_in     - RAS predicted a return this cycle
//   pred_addr_in      - predicted return address
//   resolve_valid_in  - return-type jalr resolved in execute
//   resolve_target_in - computed jalr target (rs1+imm)
//   flush_in          - external pipeline flush
//   redirect_out      - one-cycle pulse: restart fetch at redirect_addr_out
//   redirect_addr_out - corrected target, held until next redirect
//   recover_out       - high during the recovery window
//   full_out          - FIFO holds DEPTH predictions
//   empty_out         - FIFO holds no predictions
//   count_out         - FIFO occupancy
//   hit_count_out     - (stats build) matched resolves, saturating
//   miss_count_out    - (stats build) mismatched/unpredicted resolves, saturating
module return_predict_checker #(
  parameter int ADDR_W         = 64,
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     pred_valid_in,
  input  logic [ADDR_W-1:0]        pred_addr_in,
  input  logic                     resolve_valid_in,
  input  logic [ADDR_W-1:0]        resolve_target_in,
  input  logic                     flush_in,
  output logic                     redirect_out,
  output logic [ADDR_W-1:0]        redirect_addr_out,
  output logic                     recover_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic [$clog2(DEPTH):0]   count_out
`ifdef RET_PREDICT_STATS_EN
  ,
  output logic [31:0]              hit_count_out,
  output logic [31:0]              miss_count_out
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic {S_RUN, S_RECOVER} state_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     recov_cnt, recov_cnt_nxt;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] target_masked;
  logic              in_run, resolve_act, head_match, mismatch, hit, push, pop;

  // jalr clears bit 0 of the computed target
  assign target_masked = resolve_target_in & ~ADDR_W'(1);

  assign in_run      = (state == S_RUN);
  assign resolve_act = in_run & resolve_valid_in;
  assign head_match  = (mem[head] == target_masked);
  // A resolve with nothing predicted is a missed return and redirects too
  assign mismatch    = resolve_act & (empty_out | ~head_match);
  assign hit         = resolve_act & ~empty_out & head_match;
  assign pop         = resolve_act & ~empty_out;
  // full_out uses the registered count, so a same-cycle pop does not free a slot
  assign push        = pred_valid_in & ~full_out & in_run & ~flush_in & ~mismatch;

  assign empty_out   = (count == '0);
  assign full_out    = (count == CW'(DEPTH));
  assign count_out   = count;
  assign recover_out = (state == S_RECOVER);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_RUN;
      recov_cnt <= '0;
    end else begin
      state     <= state_nxt;
      recov_cnt <= recov_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    recov_cnt_nxt = recov_cnt;
    if (flush_in) begin
      state_nxt     = S_RUN;
      recov_cnt_nxt = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (mismatch) begin
            state_nxt     = S_RECOVER;
            recov_cnt_nxt = RW'(RECOVER_CYCLES - 1);
          end
        end
        S_RECOVER: begin
          if (recov_cnt == '0) state_nxt = S_RUN;
          else                 recov_cnt_nxt = recov_cnt - RW'(1);
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  // Prediction storage is deliberately left out of reset
  always_ff @(posedge clk_in) begin
    if (push) mem[tail] <= pred_addr_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      redirect_out      <= 1'b0;
      redirect_addr_out <= '0;
    end else begin
      redirect_out <= mismatch & ~flush_in;
      if (flush_in || mismatch) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        if (!flush_in) redirect_addr_out <= target_masked;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef RET_PREDICT_STATS_EN
  // Statistics survive flushes; only reset clears them
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_count_out  <= '0;
      miss_count_out <= '0;
    end else if (!flush_in) begin
      if (hit && hit_count_out != 32'hFFFF_FFFF)
        hit_count_out <= hit_count_out + 32'd1;
      if (mismatch && miss_count_out != 32'hFFFF_FFFF)
        miss_count_out <= miss_count_out + 32'd1;
    end
  end
`endif

endmodule
